// File: rtl/track_arb_pkg.sv
// Shared types and sizes for the track tile read-port arbiter.
package track_arb_pkg;

  localparam int unsigned TRACK_DEPTH  = 256;
  localparam int unsigned BRAM_LATENCY = 2;
  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned TILE_W       = 4;
  localparam int unsigned WAIT_W       = 8;

  typedef logic [ADDR_W-1:0] track_addr_t;
  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [1:0] {
    G_NONE   = 2'd0,
    G_REND   = 2'd1,
    G_PLAYER = 2'd2,
    G_OPP    = 2'd3
  } grant_t;

endpackage

// File: rtl/track_arb_tag_pipe.sv
// Grant tag shift register, aligned with the BRAM read latency; synchronous clear.
module track_arb_tag_pipe
  import track_arb_pkg::*;
#(
  parameter int unsigned DEPTH = BRAM_LATENCY
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  grant_t tag_in,
  output grant_t tag_out
);

  grant_t stage_q [DEPTH];

  // Shift the grant one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= G_NONE;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port BRAM, HIGH_PERFORMANCE variant: registered read plus output register (latency 2).
// Tile contents are loaded by the implementation flow from INIT_FILE.
module xilinx_single_port_ram_read_first #(
  parameter int unsigned RAM_WIDTH = 4,
  parameter int unsigned RAM_DEPTH = 256,
  parameter string       INIT_FILE = ""
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  // First stage: array read.
  always_ff @(posedge clka) begin
    if (ena) ram_data <= bram[addra];
  end

  // Second stage: output register with its own reset.
  always_ff @(posedge clka) begin
    if (rsta) douta <= '0;
    else if (regcea) douta <= ram_data;
  end

endmodule

// File: rtl/track_arb.sv
// Track tile BRAM owner and read-port arbiter: renderer first, physics round-robin.
// Optional feature macro: TRACK_ARB_STEAL_EN lets a starved physics requester
// steal one renderer slot after STEAL_WAIT-1 wait cycles.
module track_arb
  import track_arb_pkg::*;
#(
  parameter string       TRACK_INIT = "track.mem",
  parameter int unsigned STEAL_WAIT = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rend_active,
  input  logic [ADDR_W-1:0] rend_addr,
  output logic [TILE_W-1:0] rend_data,
  input  logic              p_req_valid,
  input  logic [ADDR_W-1:0] p_req_addr,
  output logic              p_req_ready,
  output logic              p_resp_valid,
  output logic [TILE_W-1:0] p_resp_data,
  input  logic              o_req_valid,
  input  logic [ADDR_W-1:0] o_req_addr,
  output logic              o_req_ready,
  output logic              o_resp_valid,
  output logic [TILE_W-1:0] o_resp_data
);

  grant_t      grant_c;
  grant_t      last_grant_q;
  grant_t      last_grant_d;
  grant_t      tag_s2;
  track_addr_t bram_addr_c;
  tile_t       bram_dout;
  tile_t       rend_hold_q;
  tile_t       p_hold_q;
  tile_t       o_hold_q;
  logic        p_steal_c;
  logic        o_steal_c;

`ifdef TRACK_ARB_STEAL_EN
  localparam logic [WAIT_W-1:0] STEAL_THRESH = WAIT_W'(STEAL_WAIT - 1);

  logic [WAIT_W-1:0] p_wait_q;
  logic [WAIT_W-1:0] o_wait_q;
  logic              steal_q;

  // Saturating wait counters; a steal blocks another steal on the next cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_wait_q <= '0;
      o_wait_q <= '0;
      steal_q  <= 1'b0;
    end else begin
      if (p_req_valid && !p_req_ready)
        p_wait_q <= (p_wait_q == '1) ? p_wait_q : p_wait_q + WAIT_W'(1);
      else
        p_wait_q <= '0;
      if (o_req_valid && !o_req_ready)
        o_wait_q <= (o_wait_q == '1) ? o_wait_q : o_wait_q + WAIT_W'(1);
      else
        o_wait_q <= '0;
      steal_q <= p_steal_c || o_steal_c;
    end
  end

  assign p_steal_c = rend_active && !steal_q && p_req_valid && (p_wait_q >= STEAL_THRESH);
  assign o_steal_c = rend_active && !steal_q && o_req_valid && (o_wait_q >= STEAL_THRESH);
`else
  assign p_steal_c = 1'b0;
  assign o_steal_c = 1'b0;
`endif

  // Grant decision and round-robin bookkeeping for this cycle.
  always_comb begin
    grant_c      = G_NONE;
    last_grant_d = last_grant_q;
    if (rend_active) begin
      if (p_steal_c)      grant_c = G_PLAYER;
      else if (o_steal_c) grant_c = G_OPP;
      else                grant_c = G_REND;
    end else if (p_req_valid && o_req_valid) begin
      grant_c = (last_grant_q == G_PLAYER) ? G_OPP : G_PLAYER;
    end else if (p_req_valid) begin
      grant_c = G_PLAYER;
    end else if (o_req_valid) begin
      grant_c = G_OPP;
    end
    if (grant_c == G_PLAYER || grant_c == G_OPP) last_grant_d = grant_c;
  end

  // Address mux onto the single BRAM port.
  always_comb begin
    bram_addr_c = rend_addr;
    case (grant_c)
      G_PLAYER: bram_addr_c = p_req_addr;
      G_OPP:    bram_addr_c = o_req_addr;
      default:  bram_addr_c = rend_addr;
    endcase
  end

  assign p_req_ready = p_req_valid && (grant_c == G_PLAYER);
  assign o_req_ready = o_req_valid && (grant_c == G_OPP);

  // Last physics grant and held output values between strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= G_OPP;
      rend_hold_q  <= '0;
      p_hold_q     <= '0;
      o_hold_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rend_hold_q  <= rend_data;
      p_hold_q     <= p_resp_data;
      o_hold_q     <= o_resp_data;
    end
  end

  // Route the BRAM word to whoever holds the stage-2 tag.
  assign p_resp_valid = (tag_s2 == G_PLAYER);
  assign o_resp_valid = (tag_s2 == G_OPP);
  assign rend_data    = (tag_s2 == G_REND) ? bram_dout : rend_hold_q;
  assign p_resp_data  = p_resp_valid ? bram_dout : p_hold_q;
  assign o_resp_data  = o_resp_valid ? bram_dout : o_hold_q;

  track_arb_tag_pipe #(
    .DEPTH (BRAM_LATENCY)
  ) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tag_in  (grant_c),
    .tag_out (tag_s2)
  );

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH (TILE_W),
    .RAM_DEPTH (TRACK_DEPTH),
    .INIT_FILE (TRACK_INIT)
  ) u_bram (
    .clka   (clk_in),
    .addra  (bram_addr_c),
    .ena    (1'b1),
    .rsta   (rst_in),
    .regcea (1'b1),
    .douta  (bram_dout)
  );

endmodule

// File: tb/tb_track_arb.sv
// Directed bench for track_arb; tile contents preloaded with a known pattern.
module tb_track_arb;

`ifdef TRACK_ARB_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rend_active;
  logic [7:0] rend_addr;
  logic [3:0] rend_data;
  logic       p_req_valid;
  logic [7:0] p_req_addr;
  logic       p_req_ready;
  logic       p_resp_valid;
  logic [3:0] p_resp_data;
  logic       o_req_valid;
  logic [7:0] o_req_addr;
  logic       o_req_ready;
  logic       o_resp_valid;
  logic [3:0] o_resp_data;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk_in = ~clk_in;

  track_arb #(
    .TRACK_INIT ("track.mem"),
    .STEAL_WAIT (16)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rend_active  (rend_active),
    .rend_addr    (rend_addr),
    .rend_data    (rend_data),
    .p_req_valid  (p_req_valid),
    .p_req_addr   (p_req_addr),
    .p_req_ready  (p_req_ready),
    .p_resp_valid (p_resp_valid),
    .p_resp_data  (p_resp_data),
    .o_req_valid  (o_req_valid),
    .o_req_addr   (o_req_addr),
    .o_req_ready  (o_req_ready),
    .o_resp_valid (o_resp_valid),
    .o_resp_data  (o_resp_data)
  );

  function automatic logic [3:0] mem_val(input int unsigned a);
    return 4'(a ^ (a >> 4) ^ 32'd5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rend_active = 1'b0;
    p_req_valid = 1'b0;
    o_req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dut.u_bram.bram[i] = mem_val(32'(i));
    idle();
    rst_in     = 1'b1;
    rend_addr  = 8'h00;
    p_req_addr = 8'h00;
    o_req_addr = 8'h00;
    repeat (3) tick();
    rst_in = 1'b0;
    #1;
    chk("rst_rend_data", 32'(rend_data), 32'd0);
    chk("rst_p_resp_valid", 32'(p_resp_valid), 32'd0);
    chk("rst_p_resp_data", 32'(p_resp_data), 32'd0);
    chk("rst_o_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_o_resp_data", 32'(o_resp_data), 32'd0);

    // Renderer owns the port; physics requests are refused.
    tick();
    rend_active = 1'b1; rend_addr = 8'h12;
    p_req_valid = 1'b1; p_req_addr = 8'h01;
    o_req_valid = 1'b1; o_req_addr = 8'h02;
    #1;
    chk("rend_p_ready0", 32'(p_req_ready), 32'd0);
    chk("rend_o_ready0", 32'(o_req_ready), 32'd0);
    tick(); rend_addr = 8'h13; #1;
    chk("rend_p_ready1", 32'(p_req_ready), 32'd0);
    chk("rend_o_ready1", 32'(o_req_ready), 32'd0);
    tick(); rend_addr = 8'h15; #1;
    chk("rend_p_ready2", 32'(p_req_ready), 32'd0);
    chk("rend_data_12", 32'(rend_data), 32'(mem_val(32'h12)));
    tick(); idle(); #1;
    chk("rend_data_13", 32'(rend_data), 32'(mem_val(32'h13)));
    chk("rend_no_p_resp", 32'(p_resp_valid), 32'd0);
    tick(); #1;
    chk("rend_data_15", 32'(rend_data), 32'(mem_val(32'h15)));
    tick(); #1;
    chk("rend_data_hold", 32'(rend_data), 32'(mem_val(32'h15)));

    // Both physics requesters valid: alternate P, O, P, O, P, O.
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 6) begin
        p_req_valid = 1'b1; p_req_addr = 8'(32'h40 + k / 2);
        o_req_valid = 1'b1; o_req_addr = 8'(32'h80 + k / 2);
      end else begin
        idle();
      end
      #1;
      if (k < 6) begin
        chk("tie_p_ready", 32'(p_req_ready), 32'((k % 2) == 0));
        chk("tie_o_ready", 32'(o_req_ready), 32'((k % 2) == 1));
      end
      if (k >= 2) begin
        if (((k - 2) % 2) == 0) begin
          chk("tie_p_resp_valid", 32'(p_resp_valid), 32'd1);
          chk("tie_p_resp_data", 32'(p_resp_data), 32'(mem_val(32'(32'h40 + (k - 2) / 2))));
          chk("tie_o_quiet", 32'(o_resp_valid), 32'd0);
        end else begin
          chk("tie_o_resp_valid", 32'(o_resp_valid), 32'd1);
          chk("tie_o_resp_data", 32'(o_resp_data), 32'(mem_val(32'(32'h80 + (k - 2) / 2))));
          chk("tie_p_quiet", 32'(p_resp_valid), 32'd0);
        end
      end
    end

    // Single player lookup.
    tick(); p_req_valid = 1'b1; p_req_addr = 8'h34; #1;
    chk("p1_ready", 32'(p_req_ready), 32'd1);
    chk("p1_o_ready", 32'(o_req_ready), 32'd0);
    tick(); idle(); #1;
    chk("p1_resp_early", 32'(p_resp_valid), 32'd0);
    tick(); #1;
    chk("p1_resp_valid", 32'(p_resp_valid), 32'd1);
    chk("p1_resp_data", 32'(p_resp_data), 32'(mem_val(32'h34)));
    chk("p1_o_quiet", 32'(o_resp_valid), 32'd0);
    tick(); #1;
    chk("p1_resp_single", 32'(p_resp_valid), 32'd0);
    chk("p1_data_hold", 32'(p_resp_data), 32'(mem_val(32'h34)));

    // Player held off by 10 renderer cycles, then served.
    for (int k = 0; k < 10; k++) begin
      tick();
      rend_active = 1'b1; rend_addr = 8'(32'h20 + k);
      p_req_valid = 1'b1; p_req_addr = 8'h5A;
      #1;
      chk("hold_p_ready", 32'(p_req_ready), 32'd0);
      chk("hold_no_resp", 32'(p_resp_valid), 32'd0);
    end
    tick(); rend_active = 1'b0; #1;
    chk("hold_release_ready", 32'(p_req_ready), 32'd1);
    tick(); p_req_valid = 1'b0; #1;
    chk("hold_resp_early", 32'(p_resp_valid), 32'd0);
    tick(); #1;
    chk("hold_resp_valid", 32'(p_resp_valid), 32'd1);
    chk("hold_resp_data", 32'(p_resp_data), 32'(mem_val(32'h5A)));
    tick(); #1;

    // Long renderer window with a waiting player: steal on wait cycle 16 when enabled.
    for (int k = 0; k < 22; k++) begin
      tick();
      rend_active = (k <= 20);
      rend_addr   = 8'(32'h60 + k);
      p_req_valid = (k >= 1 && k <= 16);
      p_req_addr  = 8'h9D;
      #1;
      if (k >= 1 && k <= 16)
        chk("steal_p_ready", 32'(p_req_ready), 32'(STEAL && (k == 16)));
      if (k == 17)
        chk("steal_rend_pre", 32'(rend_data), 32'(mem_val(32'h6F)));
      if (k == 18) begin
        chk("steal_rend_slot", 32'(rend_data),
            32'(STEAL ? mem_val(32'h6F) : mem_val(32'h70)));
        chk("steal_p_resp_valid", 32'(p_resp_valid), 32'(STEAL));
        chk("steal_p_resp_data", 32'(p_resp_data),
            32'(STEAL ? mem_val(32'h9D) : mem_val(32'h5A)));
      end
      if (k == 19)
        chk("steal_rend_post", 32'(rend_data), 32'(mem_val(32'h71)));
    end
    idle();
    repeat (3) tick();

    // Reset one cycle after acceptance: the response is dropped.
    tick(); p_req_valid = 1'b1; p_req_addr = 8'h77; #1;
    chk("mr_ready", 32'(p_req_ready), 32'd1);
    tick(); p_req_valid = 1'b0; rst_in = 1'b1; #1;
    tick(); rst_in = 1'b0; #1;
    chk("mr_p_resp_valid", 32'(p_resp_valid), 32'd0);
    chk("mr_p_resp_data", 32'(p_resp_data), 32'd0);
    chk("mr_rend_data", 32'(rend_data), 32'd0);
    chk("mr_o_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("mr_o_resp_data", 32'(o_resp_data), 32'd0);
    tick(); #1;
    chk("mr_p_resp_late", 32'(p_resp_valid), 32'd0);
    tick();
    p_req_valid = 1'b1; p_req_addr = 8'h03;
    o_req_valid = 1'b1; o_req_addr = 8'h04;
    #1;
    chk("mr_tie_p_first", 32'(p_req_ready), 32'd1);
    chk("mr_tie_o_wait", 32'(o_req_ready), 32'd0);
    tick(); idle();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
